// File: rtl/driver_receiver.sv
// Serial LED-driver front end: shifts data in, decodes lat pulse length into WRTGS/LATGS/LINERESET.
// Storage, cmd and cmd_valid update one cycle after lat falls; rd_data has 1-cycle latency; no backpressure.
module driver_receiver #(
    parameter int DATA_WIDTH   = 48,
    parameter int GROUPS       = 16,
    parameter int MULTIPLEXING = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sin,
    input  logic                            sclk_en,
    input  logic                            lat,
    input  logic [$clog2(GROUPS)-1:0]       rd_addr,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic [$clog2(MULTIPLEXING)-1:0] line,
    output logic                            cmd_valid,
    output logic [1:0]                      cmd,
    output logic                            ovf
);
    localparam int PW = $clog2(GROUPS);
    localparam int LW = $clog2(MULTIPLEXING);

    typedef enum logic [1:0] {
        CMD_NONE      = 2'd0,
        CMD_WRTGS     = 2'd1,
        CMD_LATGS     = 2'd2,
        CMD_LINERESET = 2'd3
    } cmd_t;

    logic [DATA_WIDTH-1:0] sr;
    logic                  lat_q;
    logic [2:0]            lat_len;
    logic [PW-1:0]         wr_ptr;
    logic [DATA_WIDTH-1:0] gs1 [GROUPS];
    logic [DATA_WIDTH-1:0] gs2 [GROUPS];

    cmd_t          dec;
    logic          do_write;
    logic          do_copy;
    logic          ptr_last;
    logic [PW-1:0] ptr_next;
    logic [LW-1:0] line_next;

    // The command is chosen by how long lat was held, and executes on its falling edge.
    always_comb begin
        dec = CMD_NONE;
        if (lat_q && !lat) begin
            case (lat_len)
                3'd1, 3'd2:             dec = CMD_WRTGS;
                3'd3, 3'd4, 3'd5, 3'd6: dec = CMD_LATGS;
                3'd7:                   dec = CMD_LINERESET;
                default:                dec = CMD_NONE;
            endcase
        end
    end

    always_comb begin
        do_write  = (dec != CMD_NONE);
        do_copy   = (dec == CMD_LATGS) || (dec == CMD_LINERESET);
        ptr_last  = (wr_ptr == PW'(GROUPS - 1));
        ptr_next  = ptr_last ? '0 : wr_ptr + 1'b1;
        line_next = (line == LW'(MULTIPLEXING - 1)) ? '0 : line + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr      <= '0;
            lat_q   <= 1'b0;
            lat_len <= 3'd0;
        end else begin
            lat_q <= lat;
            if (lat) begin
                lat_len <= (lat_len == 3'd7) ? 3'd7 : lat_len + 3'd1;
            end else begin
                lat_len <= 3'd0;
            end
            if (sclk_en) begin
                sr <= {sr[DATA_WIDTH-2:0], sin};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            line      <= '0;
            cmd_valid <= 1'b0;
            cmd       <= 2'd0;
            ovf       <= 1'b0;
        end else begin
            cmd_valid <= do_write;
            if (do_write) begin
                cmd    <= dec;
                wr_ptr <= ptr_next;
            end
            if (dec == CMD_WRTGS && ptr_last) begin
                ovf <= 1'b1;
            end
            if (do_copy) begin
                wr_ptr <= '0;
            end
            if (dec == CMD_LATGS) begin
                line <= line_next;
            end else if (dec == CMD_LINERESET) begin
                line <= '0;
            end
        end
    end

    // The write and shift share this edge, so sr here is always the pre-shift word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < GROUPS; i++) begin
                gs1[i] <= '0;
            end
        end else if (do_write) begin
            gs1[wr_ptr] <= sr;
        end
    end

    // The copy bypasses gs1 for the slot written this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < GROUPS; i++) begin
                gs2[i] <= '0;
            end
        end else if (do_copy) begin
            for (int i = 0; i < GROUPS; i++) begin
                gs2[i] <= (PW'(i) == wr_ptr) ? sr : gs1[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= gs2[rd_addr];
        end
    end
endmodule

// File: tb/tb_driver_receiver.sv
// Directed bench for driver_receiver: shift/latch commands, bank copy, overflow and reset cases.
module tb_driver_receiver;
    localparam int DW = 48;

    logic          clk;
    logic          rst;
    logic          sin;
    logic          sclk_en;
    logic          lat;
    logic [3:0]    rd_addr;
    logic [DW-1:0] rd_data;
    logic [2:0]    line;
    logic          cmd_valid;
    logic [1:0]    cmd;
    logic          ovf;

    int errors = 0;
    int checks = 0;

    driver_receiver #(.DATA_WIDTH(48), .GROUPS(16), .MULTIPLEXING(8)) dut (
        .clk(clk), .rst(rst), .sin(sin), .sclk_en(sclk_en), .lat(lat),
        .rd_addr(rd_addr), .rd_data(rd_data), .line(line),
        .cmd_valid(cmd_valid), .cmd(cmd), .ovf(ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_word(input logic [DW-1:0] w);
        for (int i = DW - 1; i >= 0; i--) begin
            sin     = w[i];
            sclk_en = 1'b1;
            tick();
        end
        sclk_en = 1'b0;
        sin     = 1'b0;
    endtask

    // Returns right after the falling-edge cycle, when cmd_valid should be visible.
    task automatic lat_pulse(input int n);
        lat = 1'b1;
        repeat (n) tick();
        lat = 1'b0;
        tick();
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a, input logic [DW-1:0] exp);
        rd_addr = a;
        tick();
        chk(tag, 64'(rd_data), 64'(exp));
    endtask

    function automatic logic [DW-1:0] wv(input int i);
        return {16'hC0DE, 16'(i), 16'(~i)};
    endfunction

    function automatic logic [DW-1:0] vv(input int i);
        return {8'h77, 8'(i), 32'hDEAD_0000 + 32'(i)};
    endfunction

    logic [DW-1:0] first_w;
    logic [DW-1:0] xw;
    logic [DW-1:0] yw;

    initial begin
        rst = 1'b1; sin = 1'b0; sclk_en = 1'b0; lat = 1'b0; rd_addr = '0;
        first_w = 48'hA5A5_5A5A_F00F;
        xw      = 48'h1234_5678_9ABC;
        yw      = {xw[DW-2:0], 1'b1};
        tick(); tick();
        chk("rst_rd_data", 64'(rd_data), 64'h0);
        chk("rst_line", 64'(line), 64'h0);
        chk("rst_cmd_valid", 64'(cmd_valid), 64'h0);
        chk("rst_cmd", 64'(cmd), 64'h0);
        chk("rst_ovf", 64'(ovf), 64'h0);
        rst = 1'b0;
        tick();

        // Single WRTGS
        shift_word(first_w);
        chk("sr_after_shift", 64'(dut.sr), 64'(first_w));
        lat_pulse(1);
        chk("wrtgs_valid", 64'(cmd_valid), 64'h1);
        chk("wrtgs_cmd", 64'(cmd), 64'h1);
        chk("wrtgs_ptr", 64'(dut.wr_ptr), 64'h1);
        chk("wrtgs_line", 64'(line), 64'h0);
        tick();
        chk("valid_pulse_end", 64'(cmd_valid), 64'h0);
        chk("cmd_held", 64'(cmd), 64'h1);

        // Fill the bank, latch with the 16th word
        for (int i = 1; i < 15; i++) begin
            shift_word(wv(i));
            lat_pulse(1);
        end
        chk("fill_ptr15", 64'(dut.wr_ptr), 64'hF);
        shift_word(wv(15));
        lat_pulse(3);
        chk("latgs_valid", 64'(cmd_valid), 64'h1);
        chk("latgs_cmd", 64'(cmd), 64'h2);
        chk("latgs_line", 64'(line), 64'h1);
        chk("latgs_ptr", 64'(dut.wr_ptr), 64'h0);
        chk("latgs_no_ovf", 64'(ovf), 64'h0);
        read_chk("rd_15", 4'd15, wv(15));
        read_chk("rd_0", 4'd0, first_w);
        read_chk("rd_7", 4'd7, wv(7));

        // Line counter wrap, LINERESET and pulse-length decode
        for (int k = 2; k <= 8; k++) begin
            lat_pulse(3);
            chk("line_seq", 64'(line), 64'(k % 8));
        end
        repeat (5) lat_pulse(4);
        chk("line_at5", 64'(line), 64'h5);
        lat_pulse(7);
        chk("linereset_cmd", 64'(cmd), 64'h3);
        chk("linereset_line", 64'(line), 64'h0);
        lat_pulse(6);
        chk("len6_cmd", 64'(cmd), 64'h2);
        chk("len6_line", 64'(line), 64'h1);
        lat_pulse(2);
        chk("len2_cmd", 64'(cmd), 64'h1);
        chk("len2_ptr", 64'(dut.wr_ptr), 64'h1);
        lat_pulse(12);
        chk("len12_cmd", 64'(cmd), 64'h3);
        chk("len12_line", 64'(line), 64'h0);
        chk("len12_ptr", 64'(dut.wr_ptr), 64'h0);

        // Read in the copy cycle returns the old gs2 word
        shift_word(xw);
        rd_addr = 4'd0;
        lat_pulse(3);
        chk("rd_during_copy", 64'(rd_data), 64'(wv(15)));
        tick();
        chk("rd_after_copy", 64'(rd_data), 64'(xw));

        // Shift on the execute cycle
        lat = 1'b1;
        tick();
        lat = 1'b0; sclk_en = 1'b1; sin = 1'b1;
        tick();
        sclk_en = 1'b0; sin = 1'b0;
        chk("simul_cmd", 64'(cmd), 64'h1);
        chk("simul_sr", 64'(dut.sr), 64'(yw));
        chk("simul_sr0", 64'(dut.sr[0]), 64'h1);
        lat_pulse(3);
        read_chk("simul_word0", 4'd0, xw);
        read_chk("simul_word1", 4'd1, yw);

        // Overflow
        rst = 1'b1;
        tick();
        chk("rst2_line", 64'(line), 64'h0);
        chk("rst2_rd", 64'(rd_data), 64'h0);
        chk("rst2_sr", 64'(dut.sr), 64'h0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 17; i++) begin
            shift_word(vv(i));
            lat_pulse(1);
            if (i == 14) chk("ovf_before", 64'(ovf), 64'h0);
            if (i == 15) begin
                chk("ovf_set", 64'(ovf), 64'h1);
                chk("ovf_wrap_ptr", 64'(dut.wr_ptr), 64'h0);
            end
            if (i == 16) begin
                chk("ovf_sticky", 64'(ovf), 64'h1);
                chk("ovf_ptr1", 64'(dut.wr_ptr), 64'h1);
            end
        end
        lat_pulse(3);
        read_chk("ovf_word0", 4'd0, vv(16));
        read_chk("ovf_word1", 4'd1, vv(16));
        read_chk("ovf_word2", 4'd2, vv(2));
        chk("ovf_after_latgs", 64'(ovf), 64'h1);
        rst = 1'b1;
        #1;
        chk("ovf_cleared", 64'(ovf), 64'h0);
        tick();
        rst = 1'b0;
        tick();

        // Reset during a lat pulse aborts it
        lat = 1'b1;
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("abort_rst_cmd", 64'(cmd), 64'h0);
        tick();
        rst = 1'b0; lat = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_valid", 64'(cmd_valid), 64'h0);
        end
        chk("abort_line", 64'(line), 64'h0);
        chk("abort_cmd", 64'(cmd), 64'h0);
        chk("abort_rd", 64'(rd_data), 64'h0);
        chk("abort_ovf", 64'(ovf), 64'h0);

        // lat high through reset: only post-release cycles count
        rst = 1'b1; lat = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        lat = 1'b0;
        tick();
        chk("relhi_valid", 64'(cmd_valid), 64'h1);
        chk("relhi_cmd", 64'(cmd), 64'h1);
        chk("relhi_line", 64'(line), 64'h0);
        chk("relhi_ptr", 64'(dut.wr_ptr), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/driver_receiver.md
DRIVER_RECEIVER -- requirements
Module: driver_receiver

Interface
REQ-001 Parameter DATA_WIDTH, default 48: common shift register length in bits.
REQ-002 Parameter GROUPS, default 16: number of GS words per line held in each GS latch bank.
REQ-003 Parameter MULTIPLEXING, default 8: number of lines; the line counter wraps at this value.
REQ-004 Port clk, input, 1: single system clock; all state is updated on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port sin, input, 1: serial data bit.
REQ-007 Port sclk_en, input, 1: shift strobe; each clk cycle with sclk_en high is one SCLK edge.
REQ-008 Port lat, input, 1: latch/command line.
REQ-009 Port rd_addr, input, clog2(GROUPS): read address into the second GS bank.
REQ-010 Port rd_data, output, DATA_WIDTH: registered read data from the second GS bank.
REQ-011 Port line, output, clog2(MULTIPLEXING): current line counter.
REQ-012 Port cmd_valid, output, 1: one-cycle pulse when a command executes.
REQ-013 Port cmd, output, 2: executed command code, 1=WRTGS, 2=LATGS, 3=LINERESET; it holds its value between pulses.
REQ-014 Port ovf, output, 1: sticky write-overflow flag.

Function
REQ-015 Shift: on each cycle with sclk_en=1, the block SHALL update sr <= {sr[DATA_WIDTH-2:0], sin}, so the MSB is the first bit received; shifting is independent of lat.
REQ-016 Pulse length: while lat=1 the block SHALL count clk cycles in lat_len (3 bits), saturating at 7; lat_len clears to 0 on the cycle after lat falls.
REQ-017 Decode: a lat falling edge (lat_q=1, lat=0) SHALL execute the command selected by lat_len: 1-2 -> WRTGS, 3-6 -> LATGS, 7 -> LINERESET.
REQ-018 WRTGS: gs1[wr_ptr] <= sr, and wr_ptr increments.
REQ-019 LATGS: perform the WRTGS write, then copy all of gs1 into gs2, reset wr_ptr to 0, and increment line modulo MULTIPLEXING (MULTIPLEXING-1 wraps to 0).
REQ-020 LINERESET: identical to LATGS except line <= 0.
REQ-021 Simultaneous shift and execute: when sclk_en=1 on the execute cycle, the write SHALL use the pre-shift sr and the shift SHALL still occur that cycle.
REQ-022 LATGS/LINERESET bank copy: the copy SHALL include the word written in the same cycle (gs2[wr_ptr] receives sr).
REQ-023 Overflow: a WRTGS-type write with wr_ptr=GROUPS-1 SHALL still write, then wrap wr_ptr to 0; if the command is WRTGS, ovf is set to 1 and stays set until reset.
REQ-024 Timing: cmd_valid and cmd SHALL update one cycle after the falling-edge cycle, i.e. registered in the same edge as the storage update.
REQ-025 Read port: rd_data <= gs2[rd_addr] every cycle, 1-cycle latency; a read in the same cycle as a copy returns the old gs2 contents.
REQ-026 lat high at reset release: with lat held high through reset and then released, the first falling edge SHALL decode from cycles counted after release only.

Reset
REQ-027 While rst=1, the following SHALL be held at 0: sr, lat_q, lat_len, wr_ptr, line, cmd_valid, cmd, ovf, rd_data, all gs1 words, all gs2 words.
REQ-028 Reset asserted mid-shift or mid-lat-pulse SHALL abort the pending command; no cmd_valid is produced afterwards for that pulse.

Verification
REQ-029 Shift 48 bits of 0xA5A5_5A5A_F00F, then lat=1 for 1 cycle -> cmd_valid with cmd=1 next cycle, gs1[0]=0xA5A55A5AF00F, wr_ptr=1, line unchanged.
REQ-030 Write 15 words via WRTGS, then the 16th word with a 3-cycle lat -> cmd=2, gs2[0..15] equal the sent words, line 0->1, wr_ptr=0; rd_addr=15 gives the 16th word one cycle later.
REQ-031 Repeat 8 LATGS lines -> line sequence 1..7,0; a 7-cycle lat at line 5 -> cmd=3, line=0.
REQ-032 17 WRTGS commands without LATGS -> ovf=1 after the 16th, gs1[0] overwritten by word 17, ovf stays 1 until rst.
REQ-033 sclk_en=1 on the lat falling-edge cycle -> the stored word excludes the new bit, and sr[0] equals the sin from that cycle.
REQ-034 rst pulse while lat has been high for 2 cycles, lat falls after release -> no cmd_valid, all outputs 0.
